// File: rtl/key_input_ctrl.sv
// Button and speed-switch front end for the flow-lights driver:
// 2-flop sync, debounce, run toggle, press strobe and freq select.
module key_input_ctrl #(
  parameter int               CNT_W   = 20,
  parameter logic [CNT_W-1:0] DEB_CNT = CNT_W'(9999)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_raw,
  input  logic [1:0] sw_raw,
  output logic       run,
  output logic       key_pulse,
  output logic [1:0] freq_set,
  output logic       freq_chg
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] PRESS_DB = 2'd1;
  localparam logic [1:0] HELD     = 2'd2;
  localparam logic [1:0] REL_DB   = 2'd3;

  logic             key_m_q, key_s_q;
  logic [1:0]       sw_m_q, sw_s_q, sw_last_q;
  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_k_q, cnt_k_d;
  logic [CNT_W-1:0] cnt_s_q, cnt_s_d;
  logic             run_q, run_d;
  logic             kp_q, kp_d;
  logic [1:0]       fs_q, fs_d;
  logic             fc_q, fc_d;

  always_comb begin
    state_d = state_q;
    cnt_k_d = cnt_k_q;
    run_d   = run_q;
    kp_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (key_s_q) begin
          state_d = PRESS_DB;
          cnt_k_d = '0;
        end
      end
      PRESS_DB: begin
        if (!key_s_q) begin
          state_d = IDLE;
        end else if (cnt_k_q == DEB_CNT) begin
          state_d = HELD;
          kp_d    = 1'b1;
          run_d   = ~run_q;
        end else begin
          cnt_k_d = cnt_k_q + CNT_W'(1);
        end
      end
      HELD: begin
        if (!key_s_q) begin
          state_d = REL_DB;
          cnt_k_d = '0;
        end
      end
      REL_DB: begin
        if (key_s_q) begin
          state_d = HELD;
        end else if (cnt_k_q == DEB_CNT) begin
          state_d = IDLE;
        end else begin
          cnt_k_d = cnt_k_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Any bit change restarts the stability window.
  always_comb begin
    fs_d    = fs_q;
    fc_d    = 1'b0;
    cnt_s_d = cnt_s_q;
    if (sw_s_q != sw_last_q) begin
      cnt_s_d = '0;
    end else if (sw_s_q != fs_q) begin
      if (cnt_s_q == DEB_CNT) begin
        fs_d    = sw_s_q;
        fc_d    = 1'b1;
        cnt_s_d = '0;
      end else begin
        cnt_s_d = cnt_s_q + CNT_W'(1);
      end
    end else begin
      cnt_s_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_m_q   <= 1'b0;
      key_s_q   <= 1'b0;
      sw_m_q    <= 2'b00;
      sw_s_q    <= 2'b00;
      sw_last_q <= 2'b00;
      state_q   <= IDLE;
      cnt_k_q   <= '0;
      cnt_s_q   <= '0;
      run_q     <= 1'b0;
      kp_q      <= 1'b0;
      fs_q      <= 2'b00;
      fc_q      <= 1'b0;
    end else begin
      key_m_q   <= key_raw;
      key_s_q   <= key_m_q;
      sw_m_q    <= sw_raw;
      sw_s_q    <= sw_m_q;
      sw_last_q <= sw_s_q;
      state_q   <= state_d;
      cnt_k_q   <= cnt_k_d;
      cnt_s_q   <= cnt_s_d;
      run_q     <= run_d;
      kp_q      <= kp_d;
      fs_q      <= fs_d;
      fc_q      <= fc_d;
    end
  end

  assign run       = run_q;
  assign key_pulse = kp_q;
  assign freq_set  = fs_q;
  assign freq_chg  = fc_q;

endmodule
